// File: rtl/pipelined_fixed_divider_if.sv
// ---------------------------------------------------------------------------
// pipelined_fixed_divider_if
// Operation/result handshake bundle for the pipelined fixed-point divider.
//
// Request side  : in_valid, in_ready, rs1, rs2, in_tag
// Response side : out_valid, out_ready, rd, out_tag, ovf, dbz
//
// Modports:
//   master - the producer/consumer around the divider (drives operands and
//            out_ready, observes results)
//   slave  - the divider itself
// ---------------------------------------------------------------------------
interface pipelined_fixed_divider_if #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 12,
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  rs1;
  logic [IN_WIDTH-1:0]  rs2;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] rd;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 ovf;
  logic                 dbz;

  modport master (
    output in_valid, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, rd, out_tag, ovf, dbz
  );

  modport slave (
    input  in_valid, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, rd, out_tag, ovf, dbz
  );
endinterface

// File: rtl/pipelined_fixed_divider.sv
// ---------------------------------------------------------------------------
// pipelined_fixed_divider
// Fully pipelined signed fixed-point divider: rd = (rs1 / rs2) * 2^OUT_FRAC,
// truncated toward zero, saturated to OUT_WIDTH bits, with a sideband tag.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - pipelined_fixed_divider_if.slave
//            in_valid/in_ready/rs1/rs2/in_tag  : operation handshake
//            out_valid/out_ready/rd/out_tag    : result handshake
//            ovf  : result saturated (non-zero divisor)
//            dbz  : divisor was zero
//
// Pipeline: accept register (magnitudes, sign, zero-divisor), N restoring
// division stages of BITS_PER_STAGE quotient bits each, and an output
// register doing sign restore + saturation. Latency N+2, one op per cycle.
// The whole pipeline stalls together when the output is held.
// ---------------------------------------------------------------------------

// One restoring-division register stage. The dividend bits and the quotient
// share one shift register: dividend bits leave at the top while quotient
// bits enter at the bottom, so after Q_BITS steps it holds the quotient.
module pfd_stage #(
  parameter int W     = 12,   // magnitude width
  parameter int QB    = 23,   // dividend/quotient width
  parameter int STEPS = 1,    // quotient bits resolved here
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          en,
  input  logic [W-1:0]  i_rem,
  input  logic [QB-1:0] i_rq,
  input  logic [W-1:0]  i_d,
  input  logic          i_s,
  input  logic          i_z,
  input  logic          i_n,
  input  logic [TW-1:0] i_tag,
  output logic [W-1:0]  o_rem,
  output logic [QB-1:0] o_rq,
  output logic [W-1:0]  o_d,
  output logic          o_s,
  output logic          o_z,
  output logic          o_n,
  output logic [TW-1:0] o_tag
);
  // One extra bit: partial remainder < divisor <= 2^(W-1), so the shifted
  // trial value always fits in W+1 bits.
  logic [W:0]    w_rem;
  logic [QB-1:0] w_rq;

  always_comb begin
    w_rem = {1'b0, i_rem};
    w_rq  = i_rq;
    for (int i = 0; i < STEPS; i++) begin
      w_rem = {w_rem[W-1:0], w_rq[QB-1]};
      w_rq  = w_rq << 1;
      if (w_rem >= {1'b0, i_d}) begin
        w_rem   = w_rem - {1'b0, i_d};
        w_rq[0] = 1'b1;
      end
    end
  end

  // Datapath only; validity travels in the top-level valid shift register.
  always_ff @(posedge clk) begin
    if (en) begin
      o_rem <= w_rem[W-1:0];
      o_rq  <= w_rq;
      o_d   <= i_d;
      o_s   <= i_s;
      o_z   <= i_z;
      o_n   <= i_n;
      o_tag <= i_tag;
    end
  end
endmodule

module pipelined_fixed_divider #(
  parameter int IN_WIDTH       = 12,
  parameter int OUT_WIDTH      = 12,
  parameter int OUT_FRAC       = 11,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_fixed_divider_if.slave  bus
);
  localparam int QB     = IN_WIDTH + OUT_FRAC;
  localparam int N      = (QB + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
  localparam int STAGES = N + 1;   // accept reg + N div stages; [STAGES] = out
  localparam int CW     = ((QB > OUT_WIDTH) ? QB : OUT_WIDTH) + 1;

  localparam logic [CW-1:0]        C_MAX    = (CW'(1) << (OUT_WIDTH-1)) - CW'(1);
  localparam logic [CW-1:0]        C_MINMAG = CW'(1) << (OUT_WIDTH-1);
  localparam logic [OUT_WIDTH-1:0] RD_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] RD_MIN   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // ---- handshake -----------------------------------------------------------
  logic [STAGES:0] r_vld_pipe;
  logic            w_adv;

  assign w_adv        = !r_vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = r_vld_pipe[STAGES];

  // Bubbles are carried as zeros; nothing moves while the output is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_vld_pipe <= '0;
    else if (w_adv)  r_vld_pipe <= {r_vld_pipe[STAGES-1:0], bus.in_valid};
  end

  // ---- stage 0: accept register --------------------------------------------
  // Negation in IN_WIDTH unsigned bits maps the most negative input to its
  // true magnitude 2^(IN_WIDTH-1).
  logic [IN_WIDTH-1:0]  w_mag1, w_mag2;
  logic [QB-1:0]        r_rq0;
  logic [IN_WIDTH-1:0]  r_d0;
  logic                 r_s0, r_z0, r_n0;
  logic [TAG_WIDTH-1:0] r_tag0;

  assign w_mag1 = bus.rs1[IN_WIDTH-1] ? (-bus.rs1) : bus.rs1;
  assign w_mag2 = bus.rs2[IN_WIDTH-1] ? (-bus.rs2) : bus.rs2;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_rq0  <= QB'(w_mag1) << OUT_FRAC;
      r_d0   <= w_mag2;
      r_s0   <= bus.rs1[IN_WIDTH-1] ^ bus.rs2[IN_WIDTH-1];
      r_z0   <= (bus.rs2 == '0);
      r_n0   <= bus.rs1[IN_WIDTH-1];
      r_tag0 <= bus.in_tag;
    end
  end

  // ---- stages 1..N: restoring division --------------------------------------
  logic [N:0][IN_WIDTH-1:0]  w_rem;
  logic [N:0][QB-1:0]        w_rq;
  logic [N:0][IN_WIDTH-1:0]  w_d;
  logic [N:0]                w_s, w_z, w_n;
  logic [N:0][TAG_WIDTH-1:0] w_tag;

  assign w_rem[0] = '0;
  assign w_rq[0]  = r_rq0;
  assign w_d[0]   = r_d0;
  assign w_s[0]   = r_s0;
  assign w_z[0]   = r_z0;
  assign w_n[0]   = r_n0;
  assign w_tag[0] = r_tag0;

  for (genvar k = 1; k <= N; k++) begin : g_stage
    // The final stage picks up the leftover bits when QB is not a multiple.
    localparam int STEPS = (k * BITS_PER_STAGE <= QB) ? BITS_PER_STAGE
                                                      : QB - (k-1) * BITS_PER_STAGE;
    pfd_stage #(
      .W(IN_WIDTH), .QB(QB), .STEPS(STEPS), .TW(TAG_WIDTH)
    ) u_stage (
      .clk   (clk),
      .en    (w_adv),
      .i_rem (w_rem[k-1]), .i_rq (w_rq[k-1]), .i_d (w_d[k-1]),
      .i_s   (w_s[k-1]),   .i_z  (w_z[k-1]),  .i_n (w_n[k-1]),
      .i_tag (w_tag[k-1]),
      .o_rem (w_rem[k]),   .o_rq (w_rq[k]),   .o_d (w_d[k]),
      .o_s   (w_s[k]),     .o_z  (w_z[k]),    .o_n (w_n[k]),
      .o_tag (w_tag[k])
    );
  end

  // Final remainder and divisor are not needed past the last stage.
  logic w_unused;
  assign w_unused = ^{w_rem[N], w_d[N]};

  // ---- output stage: sign restore, saturation, flags ------------------------
  logic [CW-1:0]        w_qe;
  logic [OUT_WIDTH-1:0] w_rd;
  logic                 w_ovf, w_dbz;

  assign w_qe = CW'(w_rq[N]);

  always_comb begin
    w_rd  = w_qe[OUT_WIDTH-1:0];
    w_ovf = 1'b0;
    w_dbz = 1'b0;
    if (w_z[N]) begin
      // Quotient is meaningless here; 0/0 counts as non-negative.
      w_dbz = 1'b1;
      w_rd  = w_n[N] ? RD_MIN : RD_MAX;
    end else if (!w_s[N]) begin
      if (w_qe > C_MAX) begin
        w_rd  = RD_MAX;
        w_ovf = 1'b1;
      end
    end else begin
      // Magnitude 2^(OUT_WIDTH-1) negates exactly to MIN without overflow.
      if (w_qe > C_MINMAG) begin
        w_rd  = RD_MIN;
        w_ovf = 1'b1;
      end else begin
        w_rd  = -w_qe[OUT_WIDTH-1:0];
      end
    end
  end

  logic [OUT_WIDTH-1:0] r_rd;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_ovf, r_dbz;

  // Flags are qualified by the valid bit so they read 0 on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_tag <= '0;
      r_ovf <= 1'b0;
      r_dbz <= 1'b0;
    end else if (w_adv) begin
      r_rd  <= w_rd;
      r_tag <= w_tag[N];
      r_ovf <= r_vld_pipe[N] & w_ovf;
      r_dbz <= r_vld_pipe[N] & w_dbz;
    end
  end

  assign bus.rd      = r_rd;
  assign bus.out_tag = r_tag;
  assign bus.ovf     = r_ovf;
  assign bus.dbz     = r_dbz;
endmodule

// File: tb/tb_pipelined_fixed_divider.sv
// Three divider configurations share one clock/reset and are exercised one
// after another: (BPS=1, FRAC=11, lat 25), (BPS=3, FRAC=11, lat 10),
// (BPS=3, FRAC=0, lat 6). Expected results are computed with plain integer
// arithmetic and queued at accept; per-DUT monitors pop and compare.
module tb_pipelined_fixed_divider;
  typedef struct {
    logic [11:0] rd;
    logic [3:0]  tag;
    logic        ovf;
    logic        dbz;
    int          acc;
    bit          cl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  logic [2:0]        in_valid_a = '0;
  logic [2:0][11:0]  rs1_a = '0, rs2_a = '0;
  logic [2:0][3:0]   tag_a = '0;
  logic [2:0]        out_ready_a = '1;
  logic [2:0]        in_ready_a, out_valid_a, ovf_a, dbz_a;
  logic [2:0][11:0]  rd_a;
  logic [2:0][3:0]   otag_a;

  exp_t sb[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got 0x%0h, expected 0x%0h", nm, g, cyc, act, exp);
    end
  endtask

  function automatic int frac_of(input int g);
    return (g == 2) ? 0 : 11;
  endfunction

  // Reference: exact rational scaled by 2^frac, truncated toward zero, clamped.
  function automatic exp_t model(input int a, input int b, input int fr);
    exp_t   e;
    longint q;
    e.rd = '0; e.tag = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.acc = 0; e.cl = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.rd  = (a >= 0) ? 12'h7FF : 12'h800;
    end else begin
      q = (longint'(a) * (longint'(1) << fr)) / longint'(b);
      if (q > 2047)       begin e.rd = 12'h7FF; e.ovf = 1'b1; end
      else if (q < -2048) begin e.rd = 12'h800; e.ovf = 1'b1; end
      else                      e.rd = 12'(q);
    end
    return e;
  endfunction

  // ---- DUTs and monitors ----------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPS = (g == 0) ? 1 : 3;
    localparam int FR  = (g == 2) ? 0 : 11;
    localparam int LAT = (12 + FR + BPS - 1) / BPS + 2;

    pipelined_fixed_divider_if #(.IN_WIDTH(12), .OUT_WIDTH(12), .TAG_WIDTH(4)) bus ();

    pipelined_fixed_divider #(
      .IN_WIDTH(12), .OUT_WIDTH(12), .OUT_FRAC(FR), .BITS_PER_STAGE(BPS), .TAG_WIDTH(4)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid  = in_valid_a[g];
    assign bus.rs1       = rs1_a[g];
    assign bus.rs2       = rs2_a[g];
    assign bus.in_tag    = tag_a[g];
    assign bus.out_ready = out_ready_a[g];
    assign in_ready_a[g]  = bus.in_ready;
    assign out_valid_a[g] = bus.out_valid;
    assign rd_a[g]        = bus.rd;
    assign otag_a[g]      = bus.out_tag;
    assign ovf_a[g]       = bus.ovf;
    assign dbz_a[g]       = bus.dbz;

    exp_t        e;
    bit          h_stall = 1'b0;
    logic [11:0] h_rd;
    logic [3:0]  h_tag;
    logic        h_ovf, h_dbz;

    always @(negedge clk) begin
      if (!rst_n) begin
        h_stall = 1'b0;
      end else begin
        chk("in_ready", g, 32'(in_ready_a[g]), 32'(!(out_valid_a[g] && !out_ready_a[g])));
        if (h_stall) begin
          chk("hold_valid", g, 32'(out_valid_a[g]), 32'd1);
          chk("hold_rd",    g, 32'(rd_a[g]),   32'(h_rd));
          chk("hold_tag",   g, 32'(otag_a[g]), 32'(h_tag));
          chk("hold_flags", g, {30'd0, ovf_a[g], dbz_a[g]}, {30'd0, h_ovf, h_dbz});
        end
        if (!out_valid_a[g])
          chk("idle_flags", g, {30'd0, ovf_a[g], dbz_a[g]}, 32'd0);
        if (out_valid_a[g] && out_ready_a[g]) begin
          if (sb[g].size() == 0) begin
            chk("unexpected_out_valid", g, 32'd1, 32'd0);
          end else begin
            e = sb[g].pop_front();
            chk("rd",  g, 32'(rd_a[g]),   32'(e.rd));
            chk("tag", g, 32'(otag_a[g]), 32'(e.tag));
            chk("ovf", g, 32'(ovf_a[g]),  32'(e.ovf));
            chk("dbz", g, 32'(dbz_a[g]),  32'(e.dbz));
            if (e.cl) chk("latency", g, 32'(cyc - e.acc), 32'(LAT));
          end
        end
        h_stall = out_valid_a[g] && !out_ready_a[g];
        h_rd = rd_a[g]; h_tag = otag_a[g]; h_ovf = ovf_a[g]; h_dbz = dbz_a[g];
      end
    end
  end

  // out_ready: held high, or toggled pseudo-randomly in the stress phase.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      out_ready_a[i] = rand_rdy ? ($urandom_range(0, 99) < 65) : 1'b1;
  end

  // ---- stimulus helpers (called at posedge+1, return at posedge+1) -----------
  task automatic send(input int g, input logic signed [11:0] a, input logic signed [11:0] b,
                      input logic [3:0] t, input bit cl);
    exp_t e;
    int   n = 0;
    bit   done = 1'b0;
    in_valid_a[g] = 1'b1; rs1_a[g] = a; rs2_a[g] = b; tag_a[g] = t;
    while (!done) begin
      @(negedge clk);
      if (in_ready_a[g]) begin
        e = model(int'(a), int'(b), frac_of(g));
        e.tag = t; e.acc = cyc; e.cl = cl;
        sb[g].push_back(e);
        done = 1'b1;
      end else if (++n > 500) begin
        chk("accept_timeout", g, 32'd1, 32'd0);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid_a[g] = 1'b0;
  endtask

  task automatic idle(input int g, input int n);
    in_valid_a[g] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty(input int g);
    int n = 0;
    while (sb[g].size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", g, 32'(sb[g].size()), 32'd0);
  endtask

  int da[12];
  int db[12];

  initial begin
    logic signed [11:0] a, b;
    da = '{512, -512, 1, -1, 1024, -2048, -2048, 2047, 100, -5, 0, 7};
    db = '{1024, 1024, 3, 3, 512, -2048, 2047, -2047, 0, 0, 0, 2};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset_out_valid", g, 32'(out_valid_a[g]), 32'd0);
      chk("reset_in_ready",  g, 32'(in_ready_a[g]),  32'd1);
      chk("reset_rd",        g, 32'(rd_a[g]),        32'd0);
      chk("reset_tag",       g, 32'(otag_a[g]),      32'd0);
      chk("reset_flags",     g, {30'd0, ovf_a[g], dbz_a[g]}, 32'd0);
    end
    rst_n = 1'b1;
    idle(0, 2);

    for (int g = 0; g < 3; g++) begin
      // Directed cases, one at a time so latency is measurable.
      for (int i = 0; i < 12; i++) begin
        send(g, 12'(da[i]), 12'(db[i]), 4'(i), 1'b1);
        wait_empty(g);
      end

      // Randomized stream with bubbles and backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
        a = 12'($urandom);
        b = 12'($urandom);
        case ($urandom_range(0, 7))
          0: b = 12'sd0;
          1: a = -12'sd2048;
          2: b = 12'($urandom_range(1, 15));
          default: ;
        endcase
        if ($urandom_range(0, 3) == 0) idle(g, $urandom_range(1, 3));
        send(g, a, b, 4'(i), 1'b0);
      end
      rand_rdy = 1'b0;
      wait_empty(g);

      // Reset with operations in flight.
      idle(g, 2);
      for (int i = 0; i < 10; i++) send(g, 12'($urandom), 12'($urandom_range(1, 2047)), 4'(i), 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", g, 32'(out_valid_a[g]), 32'd0);
      chk("midrst_in_ready",  g, 32'(in_ready_a[g]),  32'd1);
      sb[g].delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        chk("stale_after_reset", g, 32'(out_valid_a[g]), 32'd0);
        @(posedge clk); #1;
      end
      send(g, 12'sd7, 12'sd2, 4'hA, 1'b1);
      wait_empty(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1);
  end
endmodule
